// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared constants and types for the PDM microphone capture block.
//   SAMPLE_W_DEF : default bits per decimated sample
//   WORD_W       : packed output word width (four samples)
//   CLK_DIV_DEF  : default system clocks per mic_clk half-period
//   WINDOW_DEF   : default mic_clk periods per output sample
//   NUM_LANES    : samples packed per output word
//   pdm_state_e  : capture controller states
// -----------------------------------------------------------------------------
package pdm_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int NUM_LANES    = 4;
    localparam int WORD_W       = NUM_LANES * SAMPLE_W_DEF;
    localparam int CLK_DIV_DEF  = 21;
    localparam int WINDOW_DEF   = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2
    } pdm_state_e;

endpackage

// File: rtl/pdm_if.sv
// -----------------------------------------------------------------------------
// pdm_if
// Signals between the capture block, the microphone and the downstream
// RAM controller.
//   micData  : PDM bit stream from the microphone
//   mic_clk  : clock driven to the microphone
//   count_en : level enable from the controller (high = capture permitted)
//   ram_data : packed word of four samples, lane 0 in the low bits
//   ram_wr   : one-cycle write strobe, ram_data valid in that cycle
// Modports:
//   master : the capture block
//   slave  : the microphone / controller side
// -----------------------------------------------------------------------------
interface pdm_if #(
    parameter int SAMPLE_W = pdm_pkg::SAMPLE_W_DEF
) ();

    logic                    micData;
    logic                    mic_clk;
    logic                    count_en;
    logic [4*SAMPLE_W-1:0]   ram_data;
    logic                    ram_wr;

    modport master (
        input  micData,
        input  count_en,
        output mic_clk,
        output ram_data,
        output ram_wr
    );

    modport slave (
        output micData,
        output count_en,
        input  mic_clk,
        input  ram_data,
        input  ram_wr
    );

endinterface

// File: rtl/pdm_clk_gen.sv
// -----------------------------------------------------------------------------
// pdm_clk_gen
// Free-running microphone clock divider.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   mic_clk     : toggles every CLK_DIV clk cycles, starts low
//   sample_tick : high for the single clk cycle in which mic_clk is being
//                 driven 1->0 (the PDM data sample point)
// -----------------------------------------------------------------------------
module pdm_clk_gen import pdm_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic mic_clk,
    output logic sample_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             mic_clk_q, mic_clk_d;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d     = div_q;
        mic_clk_d = mic_clk_q;
        if (div_wrap) begin
            div_d     = '0;
            mic_clk_d = ~mic_clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk = mic_clk_q;
    // The edge that ends this cycle takes mic_clk low; the microphone data is
    // stable there, so this is where the capture block samples it.
    assign sample_tick = div_wrap & mic_clk_q;

endmodule

// File: rtl/pdm_capture.sv
// -----------------------------------------------------------------------------
// pdm_capture
// Decimates a PDM microphone stream by counting ones over WINDOW mic_clk
// periods, packs four such samples into one word and strobes it out.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pdm_if master (micData, count_en in; mic_clk, ram_data, ram_wr out)
// Dropping count_en during accumulation throws away the partial word; dropping
// it during the write cycle does not cancel that write.
// -----------------------------------------------------------------------------
module pdm_capture import pdm_pkg::*; #(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int WINDOW   = WINDOW_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    pdm_if.master bus
);

    localparam int                 WIN_W     = $clog2(WINDOW + 1);
    localparam int                 WORD_W_L  = NUM_LANES * SAMPLE_W;
    localparam logic [SAMPLE_W-1:0] ACC_MAX  = {SAMPLE_W{1'b1}};

    logic mic_clk;
    logic sample_tick;
    logic mic_bit;
    logic count_en;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .mic_clk     (mic_clk),
        .sample_tick (sample_tick)
    );

    assign mic_bit  = bus.micData;
    assign count_en = bus.count_en;

    pdm_state_e            state_q, state_d;
    logic [SAMPLE_W-1:0]   acc_q, acc_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [1:0]            lane_idx_q, lane_idx_d;
    // Only lanes 0..2 need storage; lane 3 goes straight into the output word.
    logic [SAMPLE_W-1:0]   lanes_q [0:2];
    logic [SAMPLE_W-1:0]   lanes_d [0:2];
    logic [WORD_W_L-1:0]   ram_data_q, ram_data_d;
    logic                  ram_wr_q, ram_wr_d;

    logic [SAMPLE_W-1:0]   acc_inc;
    logic                  last_sample;

    // Saturating add of the current PDM bit.
    assign acc_inc     = (acc_q == ACC_MAX) ? ACC_MAX : (acc_q + SAMPLE_W'(mic_bit));
    assign last_sample = (win_q == WIN_W'(WINDOW - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        win_d      = win_q;
        lane_idx_d = lane_idx_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lanes_d[i] = lanes_q[i];
        end

        case (state_q)
            // IDLE and ACCUM share one path: in IDLE everything is already
            // zero, so a sample point in the same cycle count_en rises simply
            // becomes the first bit of the first window.
            ST_IDLE, ST_ACCUM: begin
                if (!count_en) begin
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    win_d      = '0;
                    lane_idx_d = '0;
                    for (int i = 0; i < 3; i++) begin
                        lanes_d[i] = '0;
                    end
                end else begin
                    state_d = ST_ACCUM;
                    if (sample_tick) begin
                        if (last_sample) begin
                            acc_d = '0;
                            win_d = '0;
                            if (lane_idx_q == 2'd3) begin
                                ram_data_d = {acc_inc, lanes_q[2], lanes_q[1], lanes_q[0]};
                                ram_wr_d   = 1'b1;
                                lane_idx_d = '0;
                                state_d    = ST_WRITE;
                            end else begin
                                for (int i = 0; i < 3; i++) begin
                                    if (lane_idx_q == 2'(i)) begin
                                        lanes_d[i] = acc_inc;
                                    end
                                end
                                lane_idx_d = lane_idx_q + 2'd1;
                            end
                        end else begin
                            acc_d = acc_inc;
                            win_d = win_q + WIN_W'(1);
                        end
                    end
                end
            end

            // The strobe and data were registered on entry; the enable only
            // decides where to go next, so dropping it here keeps the write.
            ST_WRITE: begin
                state_d = count_en ? ST_ACCUM : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            win_q      <= '0;
            lane_idx_q <= '0;
            ram_data_q <= '0;
            ram_wr_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            win_q      <= win_d;
            lane_idx_q <= lane_idx_d;
            ram_data_q <= ram_data_d;
            ram_wr_q   <= ram_wr_d;
            for (int i = 0; i < 3; i++) begin
                lanes_q[i] <= lanes_d[i];
            end
        end
    end

    assign bus.mic_clk  = mic_clk;
    assign bus.ram_data = ram_data_q;
    assign bus.ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_pdm_capture.sv
// -----------------------------------------------------------------------------
// tb_pdm_capture
// Self-checking bench for pdm_capture (CLK_DIV=2, WINDOW=4, SAMPLE_W=8) plus a
// second instance with SAMPLE_W=2 for saturation. The reference model keeps
// the PDM bits of the word in progress in a queue and sums them per lane.
// -----------------------------------------------------------------------------
module tb_pdm_capture;

    localparam int CLK_DIV = 2;
    localparam int WINDOW  = 4;
    localparam int SW      = 8;
    localparam int SW2     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pdm_if #(.SAMPLE_W(SW))  bus ();
    pdm_if #(.SAMPLE_W(SW2)) bus2 ();

    pdm_capture #(
        .CLK_DIV  (CLK_DIV),
        .WINDOW   (WINDOW),
        .SAMPLE_W (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pdm_capture #(
        .CLK_DIV  (CLK_DIV),
        .WINDOW   (WINDOW),
        .SAMPLE_W (SW2)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int          cyc      = 0;     // rising edges since reset release
    bit          q[$];             // PDM bits of the word in progress
    logic        exp_wr   = 1'b0;
    logic [31:0] exp_data = '0;
    logic        exp_mic  = 1'b0;

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            int s;
            s = 0;
            for (int p = 0; p < WINDOW; p++) begin
                s += int'(q[l*WINDOW + p]);
            end
            if (s > (2**SW - 1)) s = 2**SW - 1;
            w[l*SW +: SW] = SW'(s);
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            q.delete();
            exp_wr   = 1'b0;
            exp_data = '0;
            exp_mic  = 1'b0;
        end else begin
            cyc++;
            exp_wr  = 1'b0;
            exp_mic = (((cyc / CLK_DIV) % 2) == 1);
            if (!bus.count_en) begin
                q.delete();
            end else if ((cyc % (2*CLK_DIV)) == 0) begin
                q.push_back(bus.micData);
                if (q.size() == 4*WINDOW) begin
                    exp_data = model_word();
                    exp_wr   = 1'b1;
                    q.delete();
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_rise;
        bus.micData  = 1'b1;
        bus.count_en = 1'b1;
        rst_n        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.mic_clk, bus.ram_wr, bus.ram_data} !== 34'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: mic_clk=%b ram_wr=%b ram_data=%h, required all 0",
                         bus.mic_clk, bus.ram_wr, bus.ram_data);
            end
            bus.micData = 1'($urandom);
        end
        bus.count_en = 1'b0;
        rst_n        = 1'b1;
        first_rise   = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.mic_clk !== exp_mic) begin
                miscompares++;
                $display("FAIL reset_mic_clk cycle %0d: got %b required %b", i, bus.mic_clk, exp_mic);
            end
            vectors++;
            if (bus.ram_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ram_wr cycle %0d: got %b required 0", i, bus.ram_wr);
            end
            if (bus.mic_clk === 1'b1 && first_rise < 0) first_rise = i;
        end
        vectors++;
        if (first_rise != CLK_DIV) begin
            miscompares++;
            $display("FAIL first_rise: got cycle %0d required cycle %0d", first_rise, CLK_DIV);
        end
    endtask

    task automatic test_all_ones();
        int writes = 0;
        bus.micData  = 1'b1;
        bus.count_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL all_ones_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            vectors++;
            if (bus.ram_data !== exp_data) begin
                miscompares++;
                $display("FAIL all_ones_data cyc %0d: got %h required %h", cyc, bus.ram_data, exp_data);
            end
            vectors++;
            if (bus.mic_clk !== exp_mic) begin
                miscompares++;
                $display("FAIL all_ones_mic_clk cyc %0d: got %b required %b", cyc, bus.mic_clk, exp_mic);
            end
            if (bus.ram_wr === 1'b1) begin
                writes++;
                vectors++;
                if (bus.ram_data !== 32'h04040404) begin
                    miscompares++;
                    $display("FAIL all_ones_word: got %h required 04040404", bus.ram_data);
                end
            end
            // Controller drops the enable for the write cycle only.
            bus.count_en = (bus.ram_wr !== 1'b1);
        end
        vectors++;
        if (writes != 3) begin
            miscompares++;
            $display("FAIL all_ones_count: got %0d writes required 3", writes);
        end
    endtask

    task automatic test_ramp();
        int writes = 0;
        @(negedge clk);
        bus.count_en = 1'b0;
        @(negedge clk);
        bus.count_en = 1'b1;
        for (int i = 0; i < 140; i++) begin
            // Window w of the word gets w+1 ones.
            bus.micData = ((q.size() % WINDOW) < (q.size() / WINDOW + 1));
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL ramp_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            vectors++;
            if (bus.ram_data !== exp_data) begin
                miscompares++;
                $display("FAIL ramp_data cyc %0d: got %h required %h", cyc, bus.ram_data, exp_data);
            end
            if (bus.ram_wr === 1'b1) begin
                writes++;
                vectors++;
                if (bus.ram_data !== 32'h04030201) begin
                    miscompares++;
                    $display("FAIL ramp_word: got %h required 04030201", bus.ram_data);
                end
            end
        end
        vectors++;
        if (writes != 2) begin
            miscompares++;
            $display("FAIL ramp_count: got %0d writes required 2", writes);
        end
    endtask

    task automatic test_abort();
        bit          hit = 1'b0;
        int          writes = 0;
        logic [31:0] held;
        bus.count_en = 1'b1;
        for (int i = 0; i < 200 && !hit; i++) begin
            bus.micData = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL abort_pre_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            if (q.size() == 2*WINDOW + 1) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL abort_reach_lane2: got timeout required 2 lanes complete");
        end
        held = exp_data;
        bus.count_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.micData = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_wr cyc %0d: got %b required 0", cyc, bus.ram_wr);
            end
            vectors++;
            if (bus.ram_data !== held) begin
                miscompares++;
                $display("FAIL abort_hold cyc %0d: got %h required %h", cyc, bus.ram_data, held);
            end
        end
        bus.count_en = 1'b1;
        for (int i = 0; i < 140; i++) begin
            bus.micData = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL abort_resume_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            vectors++;
            if (bus.ram_data !== exp_data) begin
                miscompares++;
                $display("FAIL abort_resume_data cyc %0d: got %h required %h", cyc, bus.ram_data, exp_data);
            end
            if (bus.ram_wr === 1'b1) writes++;
        end
        vectors++;
        if (writes != 2) begin
            miscompares++;
            $display("FAIL abort_resume_count: got %0d writes required 2", writes);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.micData  = 1'($urandom);
            bus.count_en = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL random_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            vectors++;
            if (bus.ram_data !== exp_data) begin
                miscompares++;
                $display("FAIL random_data cyc %0d: got %h required %h", cyc, bus.ram_data, exp_data);
            end
            vectors++;
            if (bus.mic_clk !== exp_mic) begin
                miscompares++;
                $display("FAIL random_mic_clk cyc %0d: got %b required %b", cyc, bus.mic_clk, exp_mic);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 1'b0;
        int first_wr = -1;
        bus.count_en = 1'b1;
        for (int i = 0; i < 200 && !hit; i++) begin
            bus.micData = 1'($urandom);
            @(negedge clk);
            if (q.size() == 2*WINDOW + 2) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL mid_reset_reach_lane2: got timeout required lane 2 in progress");
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.mic_clk, bus.ram_wr, bus.ram_data} !== 34'd0) begin
            miscompares++;
            $display("FAIL mid_reset_async: mic_clk=%b ram_wr=%b ram_data=%h, required all 0",
                     bus.mic_clk, bus.ram_wr, bus.ram_data);
        end
        vectors++;
        if ({bus2.mic_clk, bus2.ram_wr, bus2.ram_data} !== 10'd0) begin
            miscompares++;
            $display("FAIL mid_reset_async_sat: mic_clk=%b ram_wr=%b ram_data=%h, required all 0",
                     bus2.mic_clk, bus2.ram_wr, bus2.ram_data);
        end
        @(negedge clk);
        @(negedge clk);
        bus.micData = 1'b1;
        rst_n       = 1'b1;
        for (int i = 0; i < 100 && first_wr < 0; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.ram_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL mid_reset_wr cyc %0d: got %b required %b", cyc, bus.ram_wr, exp_wr);
            end
            if (bus.ram_wr === 1'b1) begin
                first_wr = cyc;
                vectors++;
                if (bus.ram_data !== 32'h04040404) begin
                    miscompares++;
                    $display("FAIL mid_reset_word: got %h required 04040404", bus.ram_data);
                end
            end
        end
        vectors++;
        if (first_wr != 16*2*CLK_DIV) begin
            miscompares++;
            $display("FAIL mid_reset_first_wr: got cycle %0d required cycle %0d", first_wr, 16*2*CLK_DIV);
        end
    endtask

    task automatic test_saturate();
        int writes = 0;
        for (int i = 0; i < 200 && writes < 2; i++) begin
            @(negedge clk);
            if (bus2.ram_wr === 1'b1) begin
                writes++;
                vectors++;
                if (bus2.ram_data !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL saturate_word: got %h required ff", bus2.ram_data);
                end
            end
        end
        vectors++;
        if (writes != 2) begin
            miscompares++;
            $display("FAIL saturate_count: got %0d writes required 2", writes);
        end
    endtask

    initial begin
        bus.micData   = 1'b0;
        bus.count_en  = 1'b0;
        bus2.micData  = 1'b1;
        bus2.count_en = 1'b1;
        test_reset();
        test_all_ones();
        test_ramp();
        test_abort();
        test_random();
        test_mid_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 Parameter CLK_DIV, default 'd21: system clocks per mic_clk half-period; SHALL be >= 2.
REQ-002 Parameter WINDOW, default 'd240: mic_clk periods per output sample (2.4 MHz / 10 kHz).
REQ-003 Parameter SAMPLE_W, default 'd8: bits per sample; output word is 4*SAMPLE_W bits.
REQ-004 clk  in  1  system clock; one clock; all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 micData  in  1  PDM bit stream from the microphone.
REQ-007 mic_clk  out  1  clock driven to the microphone.
REQ-008 count_en  in  1  level enable from the downstream controller; high = capture permitted.
REQ-009 ram_data  out  4*SAMPLE_W  packed word of four samples.
REQ-010 ram_wr  out  1  one-cycle write strobe; ram_data valid in that cycle.

Function
REQ-011 mic_clk SHALL toggle every CLK_DIV clk cycles continuously after reset, independent of count_en.
REQ-012 A sample point SHALL be the clk cycle in which mic_clk is driven 1->0; micData is sampled only there, one sample point per 2*CLK_DIV cycles.
REQ-013 States: IDLE, ACCUM, WRITE.
REQ-014 IDLE: accumulator, window counter and lane index held at 0; go to ACCUM the cycle count_en is high.
REQ-015 ACCUM: at each sample point, add micData to the accumulator and increment the window counter.
REQ-016 At the WINDOW-th sample point, the accumulator value (including that bit) SHALL be stored into the current lane; accumulator and window counter cleared; lane index incremented.
REQ-017 Lane 0 = ram_data[SAMPLE_W-1:0], lane 3 = ram_data[4*SAMPLE_W-1:3*SAMPLE_W].
REQ-018 Accumulator SHALL saturate at 2^SAMPLE_W-1; no wrap.
REQ-019 When lane 3 is stored, the next cycle SHALL be WRITE: ram_data updated with all four lanes, ram_wr=1 for exactly that cycle; lane index wraps to 0.
REQ-020 WRITE -> ACCUM if count_en high, else IDLE; WRITE never coincides with a sample point (CLK_DIV>=2).
REQ-021 ram_data SHALL hold its value from one ram_wr cycle until the next ram_wr cycle.
REQ-022 count_en low in any ACCUM cycle SHALL abort: partial lanes, accumulator, window counter discarded; go to IDLE; no ram_wr.
REQ-023 count_en low in the WRITE cycle (controller drops it on ram_wr) SHALL NOT suppress the write in progress.
REQ-024 After abort or IDLE, the first window SHALL start at the first sample point with count_en high.

Reset
REQ-025 rst_n low SHALL immediately force: mic_clk=0, ram_wr=0, ram_data=0, state IDLE, divider, accumulator, window counter, lane index = 0.
REQ-026 Reset asserted mid-ACCUM or in WRITE SHALL discard all partial data; no ram_wr until a full new word completes after release.
REQ-027 First mic_clk rising edge SHALL occur CLK_DIV cycles after rst_n deasserts.

Structure
REQ-028 Package pdm_pkg SHALL hold SAMPLE_W default, WORD_W=4*SAMPLE_W, default CLK_DIV/WINDOW constants, and the state enum type.
REQ-029 Sub-module pdm_clk_gen SHALL produce mic_clk and a one-cycle sample_tick; pdm_capture holds FSM, accumulator and packing.
REQ-030 Accumulator width SHALL be SAMPLE_W; window counter width $clog2(WINDOW+1).

Verification (CLK_DIV=2, WINDOW=4, SAMPLE_W=8 unless stated)
REQ-031 rst_n=0 with activity -> all outputs 0 immediately; after release mic_clk period = 4 clk, first rise at cycle 2.
REQ-032 micData=1, count_en=1 (dropped one cycle on each ram_wr) -> ram_wr every 16 sample points, 1 cycle wide, ram_data=32'h04040404.
REQ-033 Windows containing 1,2,3,4 ones in order -> ram_data=32'h04030201, ram_wr one cycle after 16th sample point.
REQ-034 count_en low after 2 lanes complete -> no ram_wr, ram_data unchanged; re-enable -> next word built from fresh windows only.
REQ-035 SAMPLE_W=2, WINDOW=4, micData=1 -> every lane saturates at 3, ram_data=8'hFF.
REQ-036 rst_n pulse mid-ACCUM of lane 2 -> no ram_wr for the interrupted word; next ram_wr only after 16 sample points post-release.
